// File: rtl/alu_seq.sv
// Handshaked sequential ALU: registered results, valid/ready on both sides,
// shift-add multiply over WIDTH cycles. Define ALU_SEQ_LTU_EN to enable op 7 (unsigned less-than).
module alu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [2:0]       op_select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic             w_accept;
  logic             w_is_mul;
  logic             w_mul_last;
  logic [WIDTH-1:0] w_result;
  logic [WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_out_data;
  logic [CW-1:0]    r_cnt;

  // A DONE result can be replaced in the same cycle it is consumed.
  assign in_ready   = !rst && ((r_state == S_IDLE) || ((r_state == S_DONE) && out_ready));
  assign w_accept   = in_valid && in_ready;
  assign w_is_mul   = (op_select == 3'd5);
  assign w_mul_last = (r_cnt == LAST);
  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign out_valid  = (r_state == S_DONE);
  assign out_data   = r_out_data;

  always_comb begin
    w_result = '0;
    case (op_select)
      3'd0: w_result = in0 | in1;
      3'd1: w_result = in0 & in1;
      3'd2: w_result = in0 ^ in1;
      3'd3: w_result = in0 + in1;
      3'd4: w_result = in0 - in1;
      3'd6: w_result = {{(WIDTH-1){1'b0}}, (in0 != in1)};
`ifdef ALU_SEQ_LTU_EN
      3'd7: w_result = {{(WIDTH-1){1'b0}}, (in0 < in1)};
`else
      3'd7: w_result = '0;
`endif
      default: w_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = w_is_mul ? S_MUL : S_DONE;
      end
      S_MUL: begin
        if (w_mul_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        if (w_accept)       w_state_next = w_is_mul ? S_MUL : S_DONE;
        else if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
    end else if (w_accept) begin
      if (w_is_mul) begin
        r_mcand  <= in0;
        r_mplier <= in1;
        r_acc    <= '0;
        r_cnt    <= '0;
      end else begin
        r_out_data <= w_result;
      end
    end else if (r_state == S_MUL) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
      if (w_mul_last) r_out_data <= w_acc_next;
    end
  end

endmodule
